// File: rtl/issue_scheduler_if.sv
// Issue scheduler interface: reservation-station request bits, flush/CDB
// handshake inputs, and the ALU / MUL-DIV issue and completion outputs.
// The master modport is the RS/pipeline side; the slave modport is the scheduler.
interface issue_scheduler_if #(
  parameter int RS_ENTRIES = 8,
  parameter int IDX_W      = 3
);
  logic [RS_ENTRIES-1:0] rs_ready;
  logic [RS_ENTRIES-1:0] rs_is_muldiv;
  logic [RS_ENTRIES-1:0] rs_is_div;
  logic                  flush;
  logic                  cdb_grant;
  logic                  alu_issue_valid;
  logic [IDX_W-1:0]      alu_issue_idx;
  logic                  muldiv_issue_valid;
  logic [IDX_W-1:0]      muldiv_issue_idx;
  logic                  muldiv_busy;
  logic                  muldiv_done;
  logic [IDX_W-1:0]      muldiv_done_idx;

  modport master (
    output rs_ready, rs_is_muldiv, rs_is_div, flush, cdb_grant,
    input  alu_issue_valid, alu_issue_idx, muldiv_issue_valid, muldiv_issue_idx,
    input  muldiv_busy, muldiv_done, muldiv_done_idx
  );

  modport slave (
    input  rs_ready, rs_is_muldiv, rs_is_div, flush, cdb_grant,
    output alu_issue_valid, alu_issue_idx, muldiv_issue_valid, muldiv_issue_idx,
    output muldiv_busy, muldiv_done, muldiv_done_idx
  );
endinterface

// File: rtl/issue_scheduler.sv
// Issue scheduler: picks RS entries for a 1-cycle ALU and a shared,
// non-pipelined MUL/DIV unit, each with its own round-robin pointer, and
// sequences the MUL/DIV unit through IDLE/BUSY/DONE until the CDB takes the result.
// Optional build macro ISSUE_SCHED_STATS_EN adds saturating issue/stall counters.
module issue_scheduler #(
  parameter int RS_ENTRIES = 8,
  parameter int IDX_W      = $clog2(RS_ENTRIES),
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 34
) (
  input  logic               clk,
  input  logic               reset,
`ifdef ISSUE_SCHED_STATS_EN
  output logic [31:0]        stat_alu_issues,
  output logic [31:0]        stat_md_issues,
  output logic [31:0]        stat_md_stalls,
`endif
  issue_scheduler_if.slave   sched
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  md_state_t          state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]   done_idx_r, done_idx_nxt_s;
  logic [IDX_W-1:0]   alu_ptr_r, md_ptr_r;

  logic [RS_ENTRIES-1:0] alu_elig_s, md_elig_s;
  logic                  alu_found_s, md_found_s;
  logic [IDX_W-1:0]      alu_pick_s, md_pick_s;
  logic                  md_avail_s, block_s;
  logic                  alu_grant_s, md_grant_s;
  logic [CNT_W-1:0]      md_load_s;

  // Round-robin search: first set bit of elig at or after ptr, wrapping.
  // Walks offsets from high to low so the smallest offset is the last write.
  function automatic logic [IDX_W:0] rr_pick(input logic [RS_ENTRIES-1:0] elig,
                                             input logic [IDX_W-1:0] ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = {IDX_W{1'b0}};
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

`ifdef ISSUE_SCHED_STATS_EN
  // Saturating 32-bit increment for the statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction
`endif

  assign alu_elig_s = sched.rs_ready & ~sched.rs_is_muldiv;
  assign md_elig_s  = sched.rs_ready &  sched.rs_is_muldiv;

  assign {alu_found_s, alu_pick_s} = rr_pick(alu_elig_s, alu_ptr_r);
  assign {md_found_s,  md_pick_s}  = rr_pick(md_elig_s,  md_ptr_r);

  // The unit can take a new op when idle, or when its finished result is
  // leaving on the CDB this very cycle (back-to-back issue).
  assign md_avail_s  = (state_r == IDLE) || ((state_r == DONE) && sched.cdb_grant);
  assign block_s     = reset | sched.flush;
  assign alu_grant_s = alu_found_s & ~block_s;
  assign md_grant_s  = md_found_s & md_avail_s & ~block_s;
  assign md_load_s   = sched.rs_is_div[md_pick_s] ? CNT_W'(DIV_CYCLES - 2)
                                                  : CNT_W'(MUL_CYCLES - 2);

  assign sched.alu_issue_valid    = alu_grant_s;
  assign sched.alu_issue_idx      = alu_grant_s ? alu_pick_s : {IDX_W{1'b0}};
  assign sched.muldiv_issue_valid = md_grant_s;
  assign sched.muldiv_issue_idx   = md_grant_s ? md_pick_s : {IDX_W{1'b0}};
  assign sched.muldiv_busy        = (state_r != IDLE);
  assign sched.muldiv_done        = (state_r == DONE);
  assign sched.muldiv_done_idx    = done_idx_r;

  // MUL/DIV occupancy FSM: next state, countdown and done index.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    done_idx_nxt_s = done_idx_r;
    if (sched.flush) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (md_grant_s) begin
            state_nxt_s    = BUSY;
            cnt_nxt_s      = md_load_s;
            done_idx_nxt_s = md_pick_s;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        BUSY: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_nxt_s = DONE;
          end else begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          if (sched.cdb_grant && md_grant_s) begin
            state_nxt_s    = BUSY;
            cnt_nxt_s      = md_load_s;
            done_idx_nxt_s = md_pick_s;
          end else if (sched.cdb_grant) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // FSM state, countdown and done-index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      done_idx_r <= {IDX_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      done_idx_r <= done_idx_nxt_s;
    end
  end

  // Round-robin pointers advance past each granted entry and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_ptr_r <= {IDX_W{1'b0}};
      md_ptr_r  <= {IDX_W{1'b0}};
    end else begin
      if (alu_grant_s) begin
        alu_ptr_r <= alu_pick_s + IDX_W'(1);
      end
      if (md_grant_s) begin
        md_ptr_r <= md_pick_s + IDX_W'(1);
      end
    end
  end

`ifdef ISSUE_SCHED_STATS_EN
  // Issue and stall statistics; frozen during flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_alu_issues <= 32'd0;
      stat_md_issues  <= 32'd0;
      stat_md_stalls  <= 32'd0;
    end else if (!sched.flush) begin
      if (alu_grant_s) begin
        stat_alu_issues <= sat_inc(stat_alu_issues);
      end
      if (md_grant_s) begin
        stat_md_issues <= sat_inc(stat_md_issues);
      end
      if (md_found_s && !md_avail_s) begin
        stat_md_stalls <= sat_inc(stat_md_stalls);
      end
    end
  end
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed self-checking bench for issue_scheduler (MUL_CYCLES=4, DIV_CYCLES=34).
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_issue_scheduler;

  logic clk;
  logic reset;
  int   tests_run;
  int   fails;

  issue_scheduler_if #(.RS_ENTRIES(8), .IDX_W(3)) bus ();

`ifdef ISSUE_SCHED_STATS_EN
  logic [31:0] stat_alu_issues, stat_md_issues, stat_md_stalls;
`endif

  issue_scheduler #(
    .RS_ENTRIES(8), .IDX_W(3), .MUL_CYCLES(4), .DIV_CYCLES(34)
  ) dut (
    .clk   (clk),
    .reset (reset),
`ifdef ISSUE_SCHED_STATS_EN
    .stat_alu_issues (stat_alu_issues),
    .stat_md_issues  (stat_md_issues),
    .stat_md_stalls  (stat_md_stalls),
`endif
    .sched (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " alu_valid"}, 32'(bus.alu_issue_valid), 32'd0);
    chk({tag, " alu_idx"},   32'(bus.alu_issue_idx),   32'd0);
    chk({tag, " md_valid"},  32'(bus.muldiv_issue_valid), 32'd0);
    chk({tag, " md_idx"},    32'(bus.muldiv_issue_idx),   32'd0);
    chk({tag, " busy"},      32'(bus.muldiv_busy),     32'd0);
    chk({tag, " done"},      32'(bus.muldiv_done),     32'd0);
    chk({tag, " done_idx"},  32'(bus.muldiv_done_idx), 32'd0);
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    // Reset asserted with requests present: everything must read 0.
    reset = 1'b1;
    bus.rs_ready = 8'hFF; bus.rs_is_muldiv = 8'h0F; bus.rs_is_div = 8'h00;
    bus.flush = 1'b0; bus.cdb_grant = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    reset = 1'b0;
    bus.rs_ready = 8'h00; bus.rs_is_muldiv = 8'h00;

    // Empty: no eligible entries.
    @(negedge clk);
    chk("empty alu_valid", 32'(bus.alu_issue_valid), 32'd0);
    chk("empty alu_idx",   32'(bus.alu_issue_idx),   32'd0);
    chk("empty md_valid",  32'(bus.muldiv_issue_valid), 32'd0);
    tick();

    // ALU round-robin: 1, 2, 7, then wrap to 0.
    bus.rs_ready = 8'b1000_0110;
    @(negedge clk);
    chk("rr0 alu_valid", 32'(bus.alu_issue_valid), 32'd1);
    chk("rr0 alu_idx",   32'(bus.alu_issue_idx),   32'd1);
    chk("rr0 md_valid",  32'(bus.muldiv_issue_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("rr1 alu_idx", 32'(bus.alu_issue_idx), 32'd2);
    tick();
    @(negedge clk);
    chk("rr2 alu_idx", 32'(bus.alu_issue_idx), 32'd7);
    tick();
    bus.rs_ready = 8'b0000_0001;
    @(negedge clk);
    chk("rr3 alu_valid", 32'(bus.alu_issue_valid), 32'd1);
    chk("rr3 alu_idx",   32'(bus.alu_issue_idx),   32'd0);
    tick();

    // MUL on entry 3 issued in "cycle 10".
    bus.rs_ready = 8'h08; bus.rs_is_muldiv = 8'h08; bus.rs_is_div = 8'h00;
    @(negedge clk);
    chk("mul md_valid",  32'(bus.muldiv_issue_valid), 32'd1);
    chk("mul md_idx",    32'(bus.muldiv_issue_idx),   32'd3);
    chk("mul alu_valid", 32'(bus.alu_issue_valid),    32'd0);
    tick();
    bus.rs_ready = 8'h00; bus.rs_is_muldiv = 8'h00;
    for (int i = 11; i <= 13; i++) begin
      @(negedge clk);
      chk("mul busy", 32'(bus.muldiv_busy), 32'd1);
      chk("mul not done", 32'(bus.muldiv_done), 32'd0);
      tick();
    end
    for (int i = 14; i <= 16; i++) begin
      @(negedge clk);
      chk("mul done hold", 32'(bus.muldiv_done), 32'd1);
      chk("mul done_idx",  32'(bus.muldiv_done_idx), 32'd3);
      tick();
    end
    bus.cdb_grant = 1'b1;
    @(negedge clk);
    chk("mul done at grant", 32'(bus.muldiv_done), 32'd1);
    tick();
    bus.cdb_grant = 1'b0;
    @(negedge clk);
    chk("mul idle busy", 32'(bus.muldiv_busy), 32'd0);
    chk("mul idle done", 32'(bus.muldiv_done), 32'd0);
    chk("mul idx held",  32'(bus.muldiv_done_idx), 32'd3);
    tick();

    // Structural hazard: DIV on entry 2, MUL on entry 5 waits, ALU entry 4 goes.
    bus.rs_ready = 8'h04; bus.rs_is_muldiv = 8'h04; bus.rs_is_div = 8'h04;
    @(negedge clk);
    chk("div md_valid", 32'(bus.muldiv_issue_valid), 32'd1);
    chk("div md_idx",   32'(bus.muldiv_issue_idx),   32'd2);
    tick();
    bus.rs_ready = 8'h30; bus.rs_is_muldiv = 8'h20; bus.rs_is_div = 8'h00;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      chk("haz md_valid", 32'(bus.muldiv_issue_valid), 32'd0);
      chk("haz busy",     32'(bus.muldiv_busy), 32'd1);
      chk("haz not done", 32'(bus.muldiv_done), 32'd0);
      if (i == 1) begin
        chk("haz alu_valid", 32'(bus.alu_issue_valid), 32'd1);
        chk("haz alu_idx",   32'(bus.alu_issue_idx),   32'd4);
      end
      tick();
      bus.rs_ready = 8'h20;
    end
    bus.cdb_grant = 1'b1;
    @(negedge clk);
    chk("haz div done",     32'(bus.muldiv_done), 32'd1);
    chk("haz div done_idx", 32'(bus.muldiv_done_idx), 32'd2);
    chk("haz b2b md_valid", 32'(bus.muldiv_issue_valid), 32'd1);
    chk("haz b2b md_idx",   32'(bus.muldiv_issue_idx),   32'd5);
    tick();
    bus.cdb_grant = 1'b0; bus.rs_ready = 8'h00; bus.rs_is_muldiv = 8'h00;
    @(negedge clk);
    chk("haz no gap busy", 32'(bus.muldiv_busy), 32'd1);
    chk("haz no gap done", 32'(bus.muldiv_done), 32'd0);
    tick();
    @(negedge clk);
    chk("haz mul pending", 32'(bus.muldiv_done), 32'd0);
    tick();
    @(negedge clk);
    chk("haz mul pending", 32'(bus.muldiv_done), 32'd0);
    tick();
    bus.cdb_grant = 1'b1;
    @(negedge clk);
    chk("haz mul done",     32'(bus.muldiv_done), 32'd1);
    chk("haz mul done_idx", 32'(bus.muldiv_done_idx), 32'd5);
    tick();
    bus.cdb_grant = 1'b0;
    @(negedge clk);
    chk("haz idle", 32'(bus.muldiv_busy), 32'd0);
    tick();

`ifdef ISSUE_SCHED_STATS_EN
    chk("stat alu",    stat_alu_issues, 32'd5);
    chk("stat md",     stat_md_issues,  32'd3);
    chk("stat stalls", stat_md_stalls,  32'd33);
`endif

    // Flush at the 5th BUSY cycle of a DIV on entry 0 (md_ptr=6 wraps to 0).
    bus.rs_ready = 8'h01; bus.rs_is_muldiv = 8'h01; bus.rs_is_div = 8'h01;
    @(negedge clk);
    chk("fl div md_idx", 32'(bus.muldiv_issue_idx), 32'd0);
    chk("fl div md_valid", 32'(bus.muldiv_issue_valid), 32'd1);
    tick();
    bus.rs_ready = 8'h00; bus.rs_is_muldiv = 8'h00; bus.rs_is_div = 8'h00;
    for (int i = 1; i <= 4; i++) begin
      tick();
    end
    bus.flush = 1'b1; bus.rs_ready = 8'hFF; bus.rs_is_muldiv = 8'hF0;
    @(negedge clk);
    chk("fl alu_valid", 32'(bus.alu_issue_valid), 32'd0);
    chk("fl md_valid",  32'(bus.muldiv_issue_valid), 32'd0);
    chk("fl busy before", 32'(bus.muldiv_busy), 32'd1);
    tick();
    bus.flush = 1'b0; bus.rs_ready = 8'h00; bus.rs_is_muldiv = 8'h00;
    @(negedge clk);
    chk("fl idle", 32'(bus.muldiv_busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("fl no done", 32'(bus.muldiv_done), 32'd0);
      tick();
    end
`ifdef ISSUE_SCHED_STATS_EN
    chk("stat fl alu",    stat_alu_issues, 32'd5);
    chk("stat fl md",     stat_md_issues,  32'd4);
    chk("stat fl stalls", stat_md_stalls,  32'd33);
`endif

    // Pointers held across flush: ALU resumes at 5, MUL/DIV at 1.
    bus.rs_ready = 8'hFF; bus.rs_is_muldiv = 8'h00;
    @(negedge clk);
    chk("ptr alu_idx", 32'(bus.alu_issue_idx), 32'd5);
    tick();
    bus.rs_is_muldiv = 8'hFF; bus.rs_is_div = 8'hFF;
    @(negedge clk);
    chk("ptr alu_valid", 32'(bus.alu_issue_valid), 32'd0);
    chk("ptr md_idx",    32'(bus.muldiv_issue_idx), 32'd1);
    tick();
    tick();
    tick();
    // Asynchronous reset in the middle of the DIV.
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("rst mid div");
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.rs_ready = 8'h00; bus.rs_is_muldiv = 8'h00; bus.rs_is_div = 8'h00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("rst no done", 32'(bus.muldiv_done), 32'd0);
      chk("rst idle",    32'(bus.muldiv_busy), 32'd0);
      tick();
    end
`ifdef ISSUE_SCHED_STATS_EN
    chk("stat rst alu", stat_alu_issues, 32'd0);
    chk("stat rst md",  stat_md_issues,  32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
